// File: rtl/ring_mem_responder_if.sv
// LOTR ring opcode/packet types and the four ring channels of a responder stop.
// The package lives here so the interface and the stop share one definition.
package lotr_pkg;

  typedef enum logic [1:0] {
    RD     = 2'd0,
    WR     = 2'd1,
    RD_RSP = 2'd2,
    WR_RSP = 2'd3
  } t_opcode;

  typedef struct packed {
    logic        valid;
    logic [9:0]  requestor;
    t_opcode     opcode;
    logic [31:0] address;
    logic [31:0] data;
  } t_ring_pkt;

endpackage

interface ring_mem_responder_if;
  import lotr_pkg::*;

  logic        RingReqInValidQ500H;
  logic [9:0]  RingReqInRequestorQ500H;
  t_opcode     RingReqInOpcodeQ500H;
  logic [31:0] RingReqInAddressQ500H;
  logic [31:0] RingReqInDataQ500H;

  logic        RingRspInValidQ500H;
  logic [9:0]  RingRspInRequestorQ500H;
  t_opcode     RingRspInOpcodeQ500H;
  logic [31:0] RingRspInAddressQ500H;
  logic [31:0] RingRspInDataQ500H;

  logic        RingReqOutValidQ502H;
  logic [9:0]  RingReqOutRequestorQ502H;
  t_opcode     RingReqOutOpcodeQ502H;
  logic [31:0] RingReqOutAddressQ502H;
  logic [31:0] RingReqOutDataQ502H;

  logic        RingRspOutValidQ502H;
  logic [9:0]  RingRspOutRequestorQ502H;
  t_opcode     RingRspOutOpcodeQ502H;
  logic [31:0] RingRspOutAddressQ502H;
  logic [31:0] RingRspOutDataQ502H;

  logic        RspFifoFullQ502H;

  // Upstream ring side: drives the Q500H inputs, observes the Q502H outputs.
  modport master (
    output RingReqInValidQ500H, RingReqInRequestorQ500H, RingReqInOpcodeQ500H,
           RingReqInAddressQ500H, RingReqInDataQ500H,
           RingRspInValidQ500H, RingRspInRequestorQ500H, RingRspInOpcodeQ500H,
           RingRspInAddressQ500H, RingRspInDataQ500H,
    input  RingReqOutValidQ502H, RingReqOutRequestorQ502H, RingReqOutOpcodeQ502H,
           RingReqOutAddressQ502H, RingReqOutDataQ502H,
           RingRspOutValidQ502H, RingRspOutRequestorQ502H, RingRspOutOpcodeQ502H,
           RingRspOutAddressQ502H, RingRspOutDataQ502H,
           RspFifoFullQ502H
  );

  modport slave (
    input  RingReqInValidQ500H, RingReqInRequestorQ500H, RingReqInOpcodeQ500H,
           RingReqInAddressQ500H, RingReqInDataQ500H,
           RingRspInValidQ500H, RingRspInRequestorQ500H, RingRspInOpcodeQ500H,
           RingRspInAddressQ500H, RingRspInDataQ500H,
    output RingReqOutValidQ502H, RingReqOutRequestorQ502H, RingReqOutOpcodeQ502H,
           RingReqOutAddressQ502H, RingReqOutDataQ502H,
           RingRspOutValidQ502H, RingRspOutRequestorQ502H, RingRspOutOpcodeQ502H,
           RingRspOutAddressQ502H, RingRspOutDataQ502H,
           RspFifoFullQ502H
  );

endinterface

// File: rtl/ring_mem_responder.sv
// Responder ring stop: forwards foreign traffic in 2 cycles, executes RD/WR hits on a
// local word memory and injects responses into free response-ring slots via a FIFO.
module ring_mem_responder
  import lotr_pkg::*;
#(
  parameter int MEM_AW         = 8,
  parameter int RSP_FIFO_DEPTH = 4
) (
  input  logic                 QClk,
  input  logic                 RstQnnnH,
  input  logic [7:0]           CoreID,
  ring_mem_responder_if.slave  ring
);

  localparam int PW  = $clog2(RSP_FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_FIFO_DEPTH);

  t_ring_pkt   req_in;
  t_ring_pkt   rsp_in;
  t_ring_pkt   req1_q;
  t_ring_pkt   rsp1_q;
  t_ring_pkt   req2_q;
  t_ring_pkt   req2_d;
  t_ring_pkt   rsp2_q;
  t_ring_pkt   rsp2_d;
  t_ring_pkt   push_pkt;
  t_ring_pkt   head_pkt;

  logic [31:0] mem_q  [2**MEM_AW];
  t_ring_pkt   fifo_q [RSP_FIFO_DEPTH];

  logic [PW-1:0] wptr_q;
  logic [PW-1:0] wptr_d;
  logic [PW-1:0] rptr_q;
  logic [PW-1:0] rptr_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          full_q;
  logic          full_d;

  logic              hit;
  logic              accept;
  logic              pop;
  logic [MEM_AW-1:0] mem_idx;
  logic [31:0]       rd_data;

  always_comb begin
    req_in           = '0;
    req_in.valid     = ring.RingReqInValidQ500H;
    req_in.requestor = ring.RingReqInRequestorQ500H;
    req_in.opcode    = ring.RingReqInOpcodeQ500H;
    req_in.address   = ring.RingReqInAddressQ500H;
    req_in.data      = ring.RingReqInDataQ500H;

    rsp_in           = '0;
    rsp_in.valid     = ring.RingRspInValidQ500H;
    rsp_in.requestor = ring.RingRspInRequestorQ500H;
    rsp_in.opcode    = ring.RingRspInOpcodeQ500H;
    rsp_in.address   = ring.RingRspInAddressQ500H;
    rsp_in.data      = ring.RingRspInDataQ500H;
  end

  // Upper local-address bits are ignored, so the memory aliases within the stop's space.
  assign mem_idx  = req1_q.address[MEM_AW+1:2];
  assign rd_data  = mem_q[mem_idx];
  assign head_pkt = fifo_q[rptr_q];

  // The full check uses the count before any same-cycle pop.
  always_comb begin
    hit    = req1_q.valid && (req1_q.address[31:24] == CoreID) &&
             ((req1_q.opcode == RD) || (req1_q.opcode == WR));
    accept = hit && (count_q < DEPTH_C);
    pop    = !rsp1_q.valid && (count_q != '0);
  end

  always_comb begin
    push_pkt       = req1_q;
    push_pkt.valid = 1'b1;
    if (req1_q.opcode == WR) begin
      push_pkt.opcode = WR_RSP;
      push_pkt.data   = req1_q.data;
    end else begin
      push_pkt.opcode = RD_RSP;
      push_pkt.data   = rd_data;
    end
  end

  always_comb begin
    req2_d  = req1_q;
    rsp2_d  = '0;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;

    if (accept) begin
      req2_d = '0;
      wptr_d = wptr_q + PW'(1);
    end

    // Pass-through responses always own the slot; the FIFO only fills idle slots.
    if (rsp1_q.valid) begin
      rsp2_d = rsp1_q;
    end else if (pop) begin
      rsp2_d = head_pkt;
      rptr_d = rptr_q + PW'(1);
    end

    count_d = count_q + CW'(accept) - CW'(pop);
    full_d  = (count_d == DEPTH_C);
  end

  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      req1_q  <= '0;
      rsp1_q  <= '0;
      req2_q  <= '0;
      rsp2_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      req1_q  <= req_in;
      rsp1_q  <= rsp_in;
      req2_q  <= req2_d;
      rsp2_q  <= rsp2_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  // Storage arrays carry no reset; the FIFO is only read while count is non-zero.
  always_ff @(posedge QClk) begin
    if (!RstQnnnH && accept) begin
      fifo_q[wptr_q] <= push_pkt;
      if (req1_q.opcode == WR) begin
        mem_q[mem_idx] <= req1_q.data;
      end
    end
  end

  assign ring.RingReqOutValidQ502H     = req2_q.valid;
  assign ring.RingReqOutRequestorQ502H = req2_q.requestor;
  assign ring.RingReqOutOpcodeQ502H    = req2_q.opcode;
  assign ring.RingReqOutAddressQ502H   = req2_q.address;
  assign ring.RingReqOutDataQ502H      = req2_q.data;

  assign ring.RingRspOutValidQ502H     = rsp2_q.valid;
  assign ring.RingRspOutRequestorQ502H = rsp2_q.requestor;
  assign ring.RingRspOutOpcodeQ502H    = rsp2_q.opcode;
  assign ring.RingRspOutAddressQ502H   = rsp2_q.address;
  assign ring.RingRspOutDataQ502H      = rsp2_q.data;

  assign ring.RspFifoFullQ502H         = full_q;

endmodule

// File: tb/tb_ring_mem_responder.sv
// Scoreboard bench for ring_mem_responder: stimulus tasks stamp expected ring outputs with
// the cycle they must appear on; a monitor compares both output rings every cycle.
module tb_ring_mem_responder;
  import lotr_pkg::*;

  typedef struct {
    int        cyc;
    t_ring_pkt pkt;
  } t_exp;

  logic        QClk = 1'b0;
  logic        RstQnnnH = 1'b1;
  logic [7:0]  CoreID = 8'h04;

  ring_mem_responder_if ring_if ();

  ring_mem_responder #(
    .MEM_AW         (8),
    .RSP_FIFO_DEPTH (4)
  ) dut (
    .QClk     (QClk),
    .RstQnnnH (RstQnnnH),
    .CoreID   (CoreID),
    .ring     (ring_if)
  );

  always #5 QClk = ~QClk;

  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;
  bit   mon_en = 1'b0;
  t_exp exp_req[$];
  t_exp exp_rsp[$];

  t_ring_pkt got_req;
  t_ring_pkt got_rsp;
  int        hit_req;
  int        hit_rsp;

  // Scoreboard monitor: a stamped expectation must match exactly on its cycle,
  // otherwise the ring must be idle with all fields zero.
  always begin
    @(posedge QClk);
    #1;
    cyc++;
    got_req = {ring_if.RingReqOutValidQ502H, ring_if.RingReqOutRequestorQ502H,
               ring_if.RingReqOutOpcodeQ502H, ring_if.RingReqOutAddressQ502H,
               ring_if.RingReqOutDataQ502H};
    got_rsp = {ring_if.RingRspOutValidQ502H, ring_if.RingRspOutRequestorQ502H,
               ring_if.RingRspOutOpcodeQ502H, ring_if.RingRspOutAddressQ502H,
               ring_if.RingRspOutDataQ502H};
    if (mon_en) begin
      hit_req = -1;
      hit_rsp = -1;
      for (int i = 0; i < exp_req.size(); i++) if (exp_req[i].cyc == cyc) hit_req = i;
      for (int i = 0; i < exp_rsp.size(); i++) if (exp_rsp[i].cyc == cyc) hit_rsp = i;

      tests++;
      if (hit_req >= 0) begin
        if (got_req !== exp_req[hit_req].pkt) begin
          failed++;
          $display("FAIL req_out cyc=%0d got=%h expected=%h", cyc, got_req, exp_req[hit_req].pkt);
        end
        exp_req.delete(hit_req);
      end else if (got_req !== '0) begin
        failed++;
        $display("FAIL req_out_idle cyc=%0d got=%h expected=0", cyc, got_req);
      end

      tests++;
      if (hit_rsp >= 0) begin
        if (got_rsp !== exp_rsp[hit_rsp].pkt) begin
          failed++;
          $display("FAIL rsp_out cyc=%0d got=%h expected=%h", cyc, got_rsp, exp_rsp[hit_rsp].pkt);
        end
        exp_rsp.delete(hit_rsp);
      end else if (got_rsp !== '0) begin
        failed++;
        $display("FAIL rsp_out_idle cyc=%0d got=%h expected=0", cyc, got_rsp);
      end
    end
  end

  function automatic t_ring_pkt mk(input logic [9:0] rq, input t_opcode op,
                                   input logic [31:0] a, input logic [31:0] d);
    t_ring_pkt p;
    p = {1'b1, rq, op, a, d};
    return p;
  endfunction

  // Advance to just after the monitor's sample of the next edge; cyc then names this cycle.
  task automatic step();
    @(posedge QClk);
    #2;
  endtask

  task automatic drive_req(input t_ring_pkt p);
    ring_if.RingReqInValidQ500H     = p.valid;
    ring_if.RingReqInRequestorQ500H = p.requestor;
    ring_if.RingReqInOpcodeQ500H    = p.opcode;
    ring_if.RingReqInAddressQ500H   = p.address;
    ring_if.RingReqInDataQ500H      = p.data;
  endtask

  task automatic drive_rsp(input t_ring_pkt p);
    ring_if.RingRspInValidQ500H     = p.valid;
    ring_if.RingRspInRequestorQ500H = p.requestor;
    ring_if.RingRspInOpcodeQ500H    = p.opcode;
    ring_if.RingRspInAddressQ500H   = p.address;
    ring_if.RingRspInDataQ500H      = p.data;
  endtask

  task automatic push_req(input int c, input t_ring_pkt p);
    t_exp e;
    e.cyc = c;
    e.pkt = p;
    exp_req.push_back(e);
  endtask

  task automatic push_rsp(input int c, input t_ring_pkt p);
    t_exp e;
    e.cyc = c;
    e.pkt = p;
    exp_rsp.push_back(e);
  endtask

  task automatic settle(input string name, input int n);
    repeat (n) step();
    tests++;
    if (exp_req.size() != 0 || exp_rsp.size() != 0) begin
      failed++;
      $display("FAIL %s_leftover got req=%0d rsp=%0d pending expected 0", name,
               exp_req.size(), exp_rsp.size());
    end
    exp_req.delete();
    exp_rsp.delete();
    $display("[TB] %s done at cycle %0d", name, cyc);
  endtask

  task automatic test_reset();
    drive_req('0);
    drive_rsp('0);
    RstQnnnH = 1'b1;
    repeat (3) step();
    tests++;
    if (got_req !== '0 || got_rsp !== '0) begin
      failed++;
      $display("FAIL reset_outputs got req=%h rsp=%h expected 0", got_req, got_rsp);
    end
    tests++;
    if (ring_if.RspFifoFullQ502H !== 1'b0) begin
      failed++;
      $display("FAIL reset_full got=%b expected 0", ring_if.RspFifoFullQ502H);
    end
    RstQnnnH = 1'b0;
    mon_en   = 1'b1;
    settle("reset", 3);
  endtask

  task automatic test_passthrough();
    t_ring_pkt p;
    step();
    p = mk(10'h055, RD, 32'h0300_0010, 32'h0000_1234);
    drive_req(p);
    push_req(cyc + 2, p);
    step();
    drive_req('0);
    settle("passthrough", 4);
  endtask

  task automatic test_write_read();
    step();
    drive_req(mk(10'h011, WR, 32'h0400_0008, 32'hDEAD_BEEF));
    push_rsp(cyc + 3, mk(10'h011, WR_RSP, 32'h0400_0008, 32'hDEAD_BEEF));
    step();
    drive_req(mk(10'h012, RD, 32'h0400_0008, 32'h0));
    push_rsp(cyc + 3, mk(10'h012, RD_RSP, 32'h0400_0008, 32'hDEAD_BEEF));
    step();
    drive_req('0);
    settle("write_read", 6);
  endtask

  task automatic test_slot_contention();
    t_ring_pkt f;
    int t0;
    step();
    t0 = cyc;
    drive_req(mk(10'h021, RD, 32'h0400_0008, 32'h0));
    push_rsp(t0 + 6, mk(10'h021, RD_RSP, 32'h0400_0008, 32'hDEAD_BEEF));
    for (int i = 1; i <= 3; i++) begin
      step();
      drive_req('0);
      // The middle one is addressed to this stop and must still pass through.
      f = mk(10'h100 + 10'(i), RD_RSP, (i == 2) ? 32'h0400_0004 : 32'h0700_0000 + i,
             32'h1111_1111 * i);
      drive_rsp(f);
      push_rsp(cyc + 2, f);
    end
    step();
    drive_rsp('0);
    settle("slot_contention", 6);
  endtask

  task automatic test_fifo_full();
    t_ring_pkt f;
    t_ring_pkt p5;
    int m;
    for (int i = 0; i < 4; i++) begin
      step();
      drive_req(mk(10'h030 + 10'(i), WR, 32'h0400_0028 + 4 * i, 32'hA000_0000 + i));
      push_rsp(cyc + 3, mk(10'h030 + 10'(i), WR_RSP, 32'h0400_0028 + 4 * i, 32'hA000_0000 + i));
    end
    step();
    drive_req('0);
    settle("fifo_fill_prep", 6);

    step();
    m = cyc;
    for (int i = 0; i < 8; i++) begin
      f = mk(10'h200 + 10'(i), WR_RSP, 32'h0900_0000 + i, 32'h5000_0000 + i);
      drive_rsp(f);
      push_rsp(cyc + 2, f);
      if (i < 4) begin
        drive_req(mk(10'h040 + 10'(i), RD, 32'h0400_0028 + 4 * i, 32'h0));
        push_rsp(m + 10 + i, mk(10'h040 + 10'(i), RD_RSP, 32'h0400_0028 + 4 * i,
                                32'hA000_0000 + i));
      end else if (i == 4) begin
        p5 = mk(10'h044, RD, 32'h0400_0028, 32'h0);
        drive_req(p5);
        push_req(cyc + 2, p5);
      end else begin
        drive_req('0);
      end
      if (i == 7) begin
        tests++;
        if (ring_if.RspFifoFullQ502H !== 1'b1) begin
          failed++;
          $display("FAIL fifo_full_flag got=%b expected 1", ring_if.RspFifoFullQ502H);
        end
      end
      step();
    end
    drive_req('0);
    drive_rsp('0);
    repeat (6) step();
    tests++;
    if (ring_if.RspFifoFullQ502H !== 1'b0) begin
      failed++;
      $display("FAIL fifo_drained_flag got=%b expected 0", ring_if.RspFifoFullQ502H);
    end
    settle("fifo_full", 2);
  endtask

  task automatic test_reset_mid();
    t_ring_pkt f;
    step();
    drive_req(mk(10'h050, WR, 32'h0400_0050, 32'h1111_2222));
    push_rsp(cyc + 3, mk(10'h050, WR_RSP, 32'h0400_0050, 32'h1111_2222));
    step();
    drive_req('0);
    settle("reset_mid_prep", 5);

    // Three RDs queue behind a busy response ring, then reset drops them.
    for (int i = 0; i < 4; i++) begin
      step();
      f = mk(10'h300 + 10'(i), RD_RSP, 32'h0A00_0000 + i, 32'h6000_0000 + i);
      drive_rsp(f);
      if (i < 3) begin
        push_rsp(cyc + 2, f);
        drive_req(mk(10'h060 + 10'(i), RD, 32'h0400_0050, 32'h0));
      end else begin
        drive_req('0);
      end
    end
    step();
    drive_rsp('0);
    RstQnnnH = 1'b1;
    step();
    RstQnnnH = 1'b0;
    tests++;
    if (ring_if.RingReqOutValidQ502H !== 1'b0 || ring_if.RingRspOutValidQ502H !== 1'b0 ||
        ring_if.RspFifoFullQ502H !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid_outputs got reqv=%b rspv=%b full=%b expected 0/0/0",
               ring_if.RingReqOutValidQ502H, ring_if.RingRspOutValidQ502H,
               ring_if.RspFifoFullQ502H);
    end
    repeat (8) step();
    drive_req(mk(10'h070, RD, 32'h0400_0050, 32'h0));
    push_rsp(cyc + 3, mk(10'h070, RD_RSP, 32'h0400_0050, 32'h1111_2222));
    step();
    drive_req('0);
    settle("reset_mid", 5);
  endtask

  task automatic test_alias_filter();
    t_ring_pkt p;
    step();
    drive_req(mk(10'h080, WR, 32'h0400_0008, 32'hCAFE_F00D));
    push_rsp(cyc + 3, mk(10'h080, WR_RSP, 32'h0400_0008, 32'hCAFE_F00D));
    step();
    drive_req(mk(10'h081, RD, 32'h04FF_F008, 32'h0));
    push_rsp(cyc + 3, mk(10'h081, RD_RSP, 32'h04FF_F008, 32'hCAFE_F00D));
    step();
    p = mk(10'h082, RD_RSP, 32'h0400_0008, 32'h7777_0000);
    drive_req(p);
    push_req(cyc + 2, p);
    step();
    p = mk(10'h083, WR, 32'h0500_0008, 32'h8888_0000);
    drive_req(p);
    push_req(cyc + 2, p);
    step();
    drive_req('0);
    settle("alias_filter", 6);
  endtask

  task automatic test_back_to_back();
    step();
    for (int i = 0; i < 4; i++) begin
      drive_req(mk(10'h090 + 10'(i), WR, 32'h0400_0100 + 4 * i, 32'hB000_0000 + i));
      push_rsp(cyc + 3, mk(10'h090 + 10'(i), WR_RSP, 32'h0400_0100 + 4 * i, 32'hB000_0000 + i));
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive_req(mk(10'h0A0 + 10'(i), RD, 32'h0400_0100 + 4 * (3 - i), 32'h0));
      push_rsp(cyc + 3, mk(10'h0A0 + 10'(i), RD_RSP, 32'h0400_0100 + 4 * (3 - i),
                           32'hB000_0000 + (3 - i)));
      step();
    end
    drive_req('0);
    settle("back_to_back", 6);
  endtask

  initial begin
    drive_req('0);
    drive_rsp('0);
    test_reset();
    test_passthrough();
    test_write_read();
    test_slot_contention();
    test_fifo_full();
    test_reset_mid();
    test_alias_filter();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ring_mem_responder.md
Name: ring_mem_responder

Overview:
- Ring stop that serves as the responder end of the LOTR request/response ring.
- Forwards all foreign traffic with a fixed 2-cycle latency (Q500H in, Q502H out).
- Consumes requests addressed to its CoreID and executes them on a local word memory.
- Injects RD_RSP/WR_RSP packets onto the response ring through a response FIFO whenever the response slot is free. Drops into the ring in place of a gpc_4t_tile/fpga_tile.

Parameters:
- MEM_AW, 8: word-address width of local memory; 2**MEM_AW 32-bit words.
- RSP_FIFO_DEPTH, 4: response FIFO entries; power of 2, >=2.

Ports:
- QClk  in  1  clock
- RstQnnnH  in  1  synchronous active-high reset
- CoreID  in  8  stop ID; static after reset
- RingReqInValidQ500H / RequestorQ500H / OpcodeQ500H / AddressQ500H / DataQ500H  in  1/10/t_opcode/32/32  request ring in
- RingRspInValidQ500H / RequestorQ500H / OpcodeQ500H / AddressQ500H / DataQ500H  in  1/10/t_opcode/32/32  response ring in
- RingReqOutValidQ502H / RequestorQ502H / OpcodeQ502H / AddressQ502H / DataQ502H  out  1/10/t_opcode/32/32  request ring out
- RingRspOutValidQ502H / RequestorQ502H / OpcodeQ502H / AddressQ502H / DataQ502H  out  1/10/t_opcode/32/32  response ring out
- RspFifoFullQ502H  out  1  registered FIFO-full status, debug
- Note: all ring fields are registered at Q501H and again at Q502H; t_opcode is lotr_pkg::t_opcode (RD, WR, RD_RSP, WR_RSP).

Behaviour:
- Reset:
  - All Q501H/Q502H registers cleared; all out valids = 0, all out fields = 0.
  - RspFifoFullQ502H = 0; FIFO pointers and count = 0.
  - Memory contents are not reset.
  - A reset mid-operation discards in-flight and queued responses; no partial packet is emitted.
- Hit decode (Q501H, on registered request):
  - Hit = ReqValid & (Address[31:24]==CoreID) & (Opcode==RD | Opcode==WR).
  - Word index = Address[MEM_AW+1:2]; Address[23:MEM_AW+2] is ignored (aliasing).
- Accept rule:
  - Accept = Hit & (FifoCount < RSP_FIFO_DEPTH), evaluated on the Q501H count, before any same-cycle pop.
  - On accept: request out valid at Q502H = 0 (slot freed); the other request-out fields are don't-care but driven to 0.
  - Hit while FIFO full: request forwarded unchanged (it recirculates and retries on its next pass).
  - Not a hit: request forwarded unchanged.
- Memory access (Q501H→Q502H edge):
  - Accepted WR writes Data to mem[index].
  - Accepted RD reads mem[index] combinationally in Q501H.
- FIFO push (same edge as the access):
  - Pushed entry: {Requestor, Opcode RD→RD_RSP / WR→WR_RSP, Address, Data}.
  - Data is the memory value for RD and the write data echoed for WR.
  - RD of a word written by an earlier accepted WR returns the new value; a WR accepted one cycle before an RD to the same index is visible to it.
- Response ring arbitration (Q501H→Q502H):
  - Registered Rsp-in valid: forward it unchanged; no pop. Pass-through always has priority.
  - Otherwise, FIFO non-empty: pop head into Rsp-out with valid=1.
  - Otherwise: Rsp-out valid=0, fields 0.
  - Responses are never consumed by this block, even ones addressed to CoreID.
- Simultaneous push and pop in one cycle: count unchanged; pointers wrap modulo RSP_FIFO_DEPTH.
- RspFifoFullQ502H = registered (count == RSP_FIFO_DEPTH).
- Latency:
  - Foreign traffic: exactly 2 cycles.
  - Accepted request at Q500H → response at Q503H minimum, plus 1 cycle per occupied pass-through response slot and per earlier queued entry.
- Ordering: responses leave in accept order (FIFO).

Test Plan:
- Pass-through: CoreID=4; request Address=0x0300_0010, Opcode=RD at cycle 0 → identical request at Req-out cycle 2; Rsp-out valid stays 0.
- Write then read: WR Addr=0x0400_0008 Data=0xDEADBEEF Req=0x011 at cycle 0; RD same address Req=0x012 at cycle 1.
  - Req-out valid=0 at cycles 2 and 3.
  - WR_RSP Data=0xDEADBEEF Req=0x011 at cycle 3.
  - RD_RSP Data=0xDEADBEEF Req=0x012 at cycle 4.
- Slot contention: foreign Rsp-in valid on cycles 1–3 plus an accepted RD at cycle 0 → foreign responses out at cycles 3–5; RD_RSP out at cycle 6.
- FIFO full: hold Rsp-in valid continuously; send 5 hitting RDs on consecutive cycles.
  - First 4 consumed; the 5th appears unchanged on Req-out.
  - RspFifoFullQ502H=1.
  - Drop Rsp-in valid → 4 responses drain in order on consecutive cycles.
- Reset mid-operation: 3 queued responses, assert RstQnnnH for 1 cycle → all out valids 0, full flag 0, nothing emitted afterwards; a subsequent RD of a previously written word returns the old value (memory preserved).
- Alias/opcode filter: RD to Addr=0x04FF_F008 (MEM_AW=8) → returns mem[2]; a request with Opcode=RD_RSP on the request ring, addressed to CoreID, is forwarded unchanged.
